// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder.
// With MEM_RESPONDER_BYTE_MASK_EN defined, the captured request carries live byte enables.
package mem_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned CNT_W  = 4;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  // Request fields latched at acceptance and held until the response completes
  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } req_t;

endpackage

// File: rtl/mem_responder_if.sv
// Initiator/responder handshake bundle for mem_responder.
// The be signal exists only when MEM_RESPONDER_BYTE_MASK_EN is defined.
interface mem_responder_if;

  logic                      req;
  logic                      rw;
  logic [mem_pkg::ADDR_W-1:0] addr;
  logic [mem_pkg::DATA_W-1:0] wdata;
  logic [mem_pkg::DATA_W-1:0] rdata;
  logic                      ack;
  logic                      err;
  logic                      busy;
`ifdef MEM_RESPONDER_BYTE_MASK_EN
  logic [mem_pkg::BE_W-1:0]   be;
`endif

  modport master (
`ifdef MEM_RESPONDER_BYTE_MASK_EN
    output be,
`endif
    output req, rw, addr, wdata,
    input  rdata, ack, err, busy
  );

  modport slave (
`ifdef MEM_RESPONDER_BYTE_MASK_EN
    input  be,
`endif
    input  req, rw, addr, wdata,
    output rdata, ack, err, busy
  );

endinterface

// File: rtl/mem_array.sv
// Word storage: synchronous byte-enabled write, combinational read, never reset.
module mem_array
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [BE_W-1:0]   be_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < int'(BE_W); b++) begin
        if (be_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder: accepts one access at a time, answers with a one-cycle ack.
// Define MEM_RESPONDER_BYTE_MASK_EN to honour per-byte write enables from the initiator.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus
);

  localparam int unsigned       IDX_W   = $clog2(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_e            state_q;
  req_t              req_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ack_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;

  logic [BE_W-1:0]   be_c;
  logic [ADDR_W-1:0] resp_addr_c;
  logic              resp_rw_c;
  logic              resp_in_range_c;
  logic              wr_en_c;
  logic [DATA_W-1:0] arr_rdata;

`ifdef MEM_RESPONDER_BYTE_MASK_EN
  assign be_c = bus.be;
`else
  assign be_c = '1;
`endif

  // With zero wait states the response is built from the live request, otherwise from the capture
  assign resp_addr_c     = (state_q == IDLE) ? bus.addr : req_q.addr;
  assign resp_rw_c       = (state_q == IDLE) ? bus.rw   : req_q.rw;
  assign resp_in_range_c = ({1'b0, resp_addr_c} < DEPTH_L);
  assign wr_en_c         = (state_q == RESP) && (req_q.rw == RW_WRITE) &&
                           ({1'b0, req_q.addr} < DEPTH_L);

  mem_array #(.DEPTH(DEPTH)) u_mem_array (
    .clk     (clk),
    .we_i    (wr_en_c),
    .be_i    (req_q.be),
    .waddr_i (req_q.addr[IDX_W-1:0]),
    .wdata_i (req_q.wdata),
    .raddr_i (resp_addr_c[IDX_W-1:0]),
    .rdata_o (arr_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (bus.req) begin
            req_q <= '{rw: bus.rw, addr: bus.addr, wdata: bus.wdata, be: be_c};
            if (WAIT_CYCLES == 0) begin
              state_q <= RESP;
              ack_q   <= 1'b1;
              err_q   <= !resp_in_range_c;
              rdata_q <= (resp_rw_c == RW_READ && resp_in_range_c) ? arr_rdata : '0;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_W'(WAIT_CYCLES - 1);
            end
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q <= RESP;
            ack_q   <= 1'b1;
            err_q   <= !resp_in_range_c;
            rdata_q <= (resp_rw_c == RW_READ && resp_in_range_c) ? arr_rdata : '0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;
  assign bus.busy  = (state_q != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Randomised self-checking bench for mem_responder (DEPTH=256/WAIT=2 and DEPTH=16/WAIT=0).
module tb_mem_responder;

  localparam int WA = 2;
  localparam int DA = 256;
  localparam int DB = 16;

  logic clk;
  logic rst;
  logic [3:0] cur_be;
  int n_tests;
  int n_fail;

  logic [31:0] model_a [DA];
  logic [31:0] model_b [DB];

  mem_responder_if ifa ();
  mem_responder_if ifb ();

  mem_responder #(.DEPTH(DA), .WAIT_CYCLES(WA)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  mem_responder #(.DEPTH(DB), .WAIT_CYCLES(0))  dut_b (.clk(clk), .rst(rst), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  // One access on DUT A (sel=0) or B (sel=1); lat counts cycles from the request cycle to ack
  task automatic access(input bit sel, input logic rw, input logic [15:0] addr,
                        input logic [31:0] wdata, output int lat, output logic [31:0] rd,
                        output logic er, output logic bsy);
    if (!sel) begin
      ifa.req = 1'b1; ifa.rw = rw; ifa.addr = addr; ifa.wdata = wdata;
`ifdef MEM_RESPONDER_BYTE_MASK_EN
      ifa.be = cur_be;
`endif
    end else begin
      ifb.req = 1'b1; ifb.rw = rw; ifb.addr = addr; ifb.wdata = wdata;
`ifdef MEM_RESPONDER_BYTE_MASK_EN
      ifb.be = cur_be;
`endif
    end
    lat = 0; rd = '0; er = 1'b0; bsy = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        ifa.req = 1'b0; ifb.req = 1'b0;
        bsy = sel ? ifb.busy : ifa.busy;
      end
      if ((sel ? ifb.ack : ifa.ack) === 1'b1) begin
        lat = k;
        rd  = sel ? ifb.rdata : ifa.rdata;
        er  = sel ? ifb.err : ifa.err;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifa.req = 1'b0; ifa.rw = 1'b0; ifa.addr = '0; ifa.wdata = '0;
    ifb.req = 1'b0; ifb.rw = 1'b0; ifb.addr = '0; ifb.wdata = '0;
`ifdef MEM_RESPONDER_BYTE_MASK_EN
    ifa.be = 4'hF; ifb.be = 4'hF;
`endif
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (ifa.ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", ifa.ack); end
    n_tests++; if (ifa.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", ifa.err); end
    n_tests++; if (ifa.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", ifa.busy); end
    n_tests++; if (ifa.rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", ifa.rdata); end
    n_tests++; if (ifb.busy !== 1'b0 || ifb.ack !== 1'b0) begin
      n_fail++; $display("FAIL reset_b: got busy=%b ack=%b expected 0/0", ifb.busy, ifb.ack);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_preload();
    int lat; logic [31:0] rd; logic er; logic bsy; logic [31:0] d;
    for (int i = 0; i < DA; i++) begin
      d = $urandom;
      access(1'b0, 1'b1, 16'(i), d, lat, rd, er, bsy);
      model_a[i] = merge(32'h0, d, 4'hF);
      n_tests++;
      if (lat != WA + 1 || er !== 1'b0 || bsy !== 1'b1) begin
        n_fail++; $display("FAIL preload_a[%0d]: got lat=%0d err=%b busy=%b expected %0d/0/1", i, lat, er, bsy, WA + 1);
      end
    end
    for (int i = 0; i < DB; i++) begin
      d = $urandom;
      access(1'b1, 1'b1, 16'(i), d, lat, rd, er, bsy);
      model_b[i] = d;
      n_tests++;
      if (lat != 1 || er !== 1'b0) begin
        n_fail++; $display("FAIL preload_b[%0d]: got lat=%0d err=%b expected 1/0", i, lat, er);
      end
    end
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] rd; logic er; logic bsy;
    access(1'b0, 1'b1, 16'd5, 32'hDEADBEEF, lat, rd, er, bsy);
    model_a[5] = 32'hDEADBEEF;
    n_tests++; if (lat != 3 || er !== 1'b0 || rd !== 32'h0) begin
      n_fail++; $display("FAIL wr5: got lat=%0d err=%b rdata=%h expected 3/0/0", lat, er, rd);
    end
    access(1'b0, 1'b0, 16'd5, 32'h0, lat, rd, er, bsy);
    n_tests++; if (lat != 3) begin n_fail++; $display("FAIL rd5_lat: got %0d expected 3", lat); end
    n_tests++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
      n_fail++; $display("FAIL rd5_data: got %h err=%b expected deadbeef err=0", rd, er);
    end
  endtask

  task automatic test_out_of_range();
    int lat; logic [31:0] rd; logic er; logic bsy; int bad;
    access(1'b0, 1'b0, 16'd300, 32'h0, lat, rd, er, bsy);
    n_tests++; if (lat != 3 || er !== 1'b1 || rd !== 32'h0) begin
      n_fail++; $display("FAIL rd300: got lat=%0d err=%b rdata=%h expected 3/1/0", lat, er, rd);
    end
    access(1'b0, 1'b0, 16'(DA), 32'h0, lat, rd, er, bsy);
    n_tests++; if (er !== 1'b1 || rd !== 32'h0) begin
      n_fail++; $display("FAIL rd_depth: got err=%b rdata=%h expected 1/0", er, rd);
    end
    access(1'b0, 1'b0, 16'(DA - 1), 32'h0, lat, rd, er, bsy);
    n_tests++; if (er !== 1'b0 || rd !== model_a[DA-1]) begin
      n_fail++; $display("FAIL rd_last: got err=%b rdata=%h expected 0/%h", er, rd, model_a[DA-1]);
    end
    access(1'b0, 1'b1, 16'd300, $urandom, lat, rd, er, bsy);
    n_tests++; if (lat != 3 || er !== 1'b1) begin
      n_fail++; $display("FAIL wr300: got lat=%0d err=%b expected 3/1", lat, er);
    end
    access(1'b0, 1'b1, 16'hFFFF, $urandom, lat, rd, er, bsy);
    bad = 0;
    for (int i = 0; i < DA; i++) begin
      access(1'b0, 1'b0, 16'(i), 32'h0, lat, rd, er, bsy);
      n_tests++;
      if (rd !== model_a[i] || er !== 1'b0) begin
        n_fail++; bad++;
        if (bad < 5) $display("FAIL oor_scan[%0d]: got %h expected %h", i, rd, model_a[i]);
      end
    end
  endtask

  task automatic test_random();
    int lat; logic [31:0] rd; logic er; logic bsy; logic [31:0] d; int a; logic w;
    for (int n = 0; n < 80; n++) begin
      a = $urandom_range(0, DA + 63);
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      access(1'b0, w, 16'(a), d, lat, rd, er, bsy);
      n_tests++;
      if (w) begin
        if (a < DA) model_a[a] = merge(model_a[a], d, cur_be);
        if (lat != WA + 1 || er !== (a >= DA) || rd !== 32'h0) begin
          n_fail++; $display("FAIL rand_wr a=%0d: got lat=%0d err=%b rdata=%h", a, lat, er, rd);
        end
      end else begin
        if (lat != WA + 1 || er !== (a >= DA) || rd !== ((a < DA) ? model_a[a] : 32'h0)) begin
          n_fail++; $display("FAIL rand_rd a=%0d: got lat=%0d err=%b rdata=%h expected %h", a, lat, er, rd,
                             (a < DA) ? model_a[a] : 32'h0);
        end
      end
    end
  endtask

  // req held high: accepted every WA+2 cycles, addresses presented while busy are dropped
  task automatic test_back_to_back();
    logic [15:0] addrs [48];
    int c; bit exp_ack; bit exp_busy; logic [31:0] exp_rd;
    for (int t = 0; t < 48; t++) addrs[t] = 16'($urandom_range(0, DA - 1));
    ifa.req = 1'b1; ifa.rw = 1'b0;
    for (int t = 0; t < 40; t++) begin
      ifa.addr = addrs[t];
      @(posedge clk); #1;
      c = t + 1;
      exp_ack  = (c >= WA + 1) && (((c - (WA + 1)) % (WA + 2)) == 0);
      exp_busy = (c % (WA + 2)) != 0;
      exp_rd   = exp_ack ? model_a[addrs[c-(WA+1)]] : 32'h0;
      n_tests++;
      if (ifa.ack !== exp_ack || ifa.busy !== exp_busy || ifa.rdata !== exp_rd) begin
        n_fail++; $display("FAIL b2b c=%0d: got ack=%b busy=%b rdata=%h expected %b/%b/%h",
                           c, ifa.ack, ifa.busy, ifa.rdata, exp_ack, exp_busy, exp_rd);
      end
    end
    ifa.req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    int lat; logic [31:0] rd; logic er; logic bsy; int seen;
    ifa.req = 1'b1; ifa.rw = 1'b1; ifa.addr = 16'd7; ifa.wdata = 32'h12345678;
    @(posedge clk); #1;
    ifa.req = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_tests++; if (ifa.busy !== 1'b0 || ifa.ack !== 1'b0) begin
      n_fail++; $display("FAIL rst_wait: got busy=%b ack=%b expected 0/0", ifa.busy, ifa.ack);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (ifa.ack === 1'b1) seen++;
    end
    n_tests++; if (seen != 0) begin n_fail++; $display("FAIL rst_wait_noack: got %0d acks expected 0", seen); end
    access(1'b0, 1'b0, 16'd7, 32'h0, lat, rd, er, bsy);
    n_tests++; if (rd !== model_a[7]) begin n_fail++; $display("FAIL rst_wait_keep: got %h expected %h", rd, model_a[7]); end

    // abort from the ack cycle itself
    ifa.req = 1'b1; ifa.rw = 1'b1; ifa.addr = 16'd9; ifa.wdata = ~model_a[9];
    @(posedge clk); #1;
    ifa.req = 1'b0;
    repeat (WA) begin @(posedge clk); #1; end
    n_tests++; if (ifa.ack !== 1'b1) begin n_fail++; $display("FAIL rst_resp_pre: got ack=%b expected 1", ifa.ack); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if (ifa.busy !== 1'b0 || ifa.ack !== 1'b0) begin
      n_fail++; $display("FAIL rst_resp: got busy=%b ack=%b expected 0/0", ifa.busy, ifa.ack);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    access(1'b0, 1'b0, 16'd9, 32'h0, lat, rd, er, bsy);
    n_tests++; if (rd !== model_a[9]) begin n_fail++; $display("FAIL rst_resp_keep: got %h expected %h", rd, model_a[9]); end
  endtask

  task automatic test_zero_wait();
    int lat; logic [31:0] rd; logic er; logic bsy; logic [31:0] d;
    d = $urandom;
    access(1'b1, 1'b1, 16'd0, d, lat, rd, er, bsy);
    model_b[0] = d;
    n_tests++; if (lat != 1 || er !== 1'b0 || bsy !== 1'b1) begin
      n_fail++; $display("FAIL zw_wr: got lat=%0d err=%b busy=%b expected 1/0/1", lat, er, bsy);
    end
    access(1'b1, 1'b0, 16'd0, 32'h0, lat, rd, er, bsy);
    n_tests++; if (lat != 1 || rd !== model_b[0]) begin
      n_fail++; $display("FAIL zw_rd: got lat=%0d rdata=%h expected 1/%h", lat, rd, model_b[0]);
    end
    access(1'b1, 1'b0, 16'(DB), 32'h0, lat, rd, er, bsy);
    n_tests++; if (lat != 1 || er !== 1'b1 || rd !== 32'h0) begin
      n_fail++; $display("FAIL zw_oor: got lat=%0d err=%b rdata=%h expected 1/1/0", lat, er, rd);
    end
    access(1'b1, 1'b0, 16'(DB - 1), 32'h0, lat, rd, er, bsy);
    n_tests++; if (er !== 1'b0 || rd !== model_b[DB-1]) begin
      n_fail++; $display("FAIL zw_last: got err=%b rdata=%h expected 0/%h", er, rd, model_b[DB-1]);
    end
  endtask

`ifdef MEM_RESPONDER_BYTE_MASK_EN
  task automatic test_byte_mask();
    int lat; logic [31:0] rd; logic er; logic bsy;
    cur_be = 4'hF;
    access(1'b0, 1'b1, 16'd12, 32'hFFFFFFFF, lat, rd, er, bsy);
    model_a[12] = merge(model_a[12], 32'hFFFFFFFF, cur_be);
    cur_be = 4'b0101;
    access(1'b0, 1'b1, 16'd12, 32'h00000000, lat, rd, er, bsy);
    model_a[12] = merge(model_a[12], 32'h0, cur_be);
    cur_be = 4'hF;
    access(1'b0, 1'b0, 16'd12, 32'h0, lat, rd, er, bsy);
    n_tests++; if (rd !== 32'hFF00FF00) begin n_fail++; $display("FAIL be_0101: got %h expected ff00ff00", rd); end
    cur_be = 4'b0000;
    access(1'b0, 1'b1, 16'd12, 32'h12345678, lat, rd, er, bsy);
    n_tests++; if (lat != WA + 1 || er !== 1'b0) begin
      n_fail++; $display("FAIL be_0000_ack: got lat=%0d err=%b expected %0d/0", lat, er, WA + 1);
    end
    cur_be = 4'hF;
    access(1'b0, 1'b0, 16'd12, 32'h0, lat, rd, er, bsy);
    n_tests++; if (rd !== model_a[12]) begin n_fail++; $display("FAIL be_0000_keep: got %h expected %h", rd, model_a[12]); end
  endtask
`endif

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cur_be  = 4'hF;
    test_reset();
    test_preload();
    test_write_read();
    test_out_of_range();
    test_random();
    test_back_to_back();
    test_reset_abort();
    test_zero_wait();
`ifdef MEM_RESPONDER_BYTE_MASK_EN
    test_byte_mask();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
